// File: rtl/types.sv
// Shared types for the trap controller slice.
// Holds the execution-result record offered to the trap controller, the
// exception code enum, the general-purpose register type, the trap FSM
// state enum, machine-mode CSR addresses and mstatus bit positions.
package types;

  typedef logic [31:0] gpreg;

  // Machine exception codes; the numeric value is what lands in mcause.
  typedef enum logic [3:0] {
    EX_INSTR_MISALIGNED = 4'd0,
    EX_INSTR_FAULT      = 4'd1,
    EX_ILLEGAL_INSTR    = 4'd2,
    EX_BREAKPOINT       = 4'd3,
    EX_LOAD_MISALIGNED  = 4'd4,
    EX_LOAD_FAULT       = 4'd5,
    EX_STORE_MISALIGNED = 4'd6,
    EX_STORE_FAULT      = 4'd7,
    EX_ECALL_U          = 4'd8,
    EX_ECALL_S          = 4'd9,
    EX_ECALL_M          = 4'd11
  } ex_type;

  typedef struct packed {
    logic   ex_valid;   // instruction raised an exception
    ex_type ex;         // exception code
    gpreg   ex_tval;    // trap value (bad address / instruction bits)
    logic   ret_valid;  // instruction is an MRET
  } exec_result;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    DRAIN    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

endpackage

// File: rtl/trap_csr.sv
// Machine trap CSR file: mstatus (MIE/MPIE only), mtvec, mepc, mcause and,
// when the TRAP_MTVAL_EN macro is defined, mtval.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   trap_take                 exception accepted this cycle
//   ret_take                  MRET accepted this cycle
//   trap_pc/cause/tval        exception details captured on trap_take
//   csr_addr/we/wdata         software CSR write port
//   csr_rdata                 combinational read data (unmapped -> 0)
//   mtvec, mepc               current values, used for redirect targets
// Hardware trap/return updates take priority over a software write to the
// same register in the same cycle.
module trap_csr
  import types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_take,
  input  logic        ret_take,
  input  gpreg        trap_pc,
  input  ex_type      trap_cause,
  input  gpreg        trap_tval,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  gpreg        csr_wdata,
  output gpreg        csr_rdata,
  output gpreg        mtvec,
  output gpreg        mepc
);

  logic mie_q;
  logic mpie_q;
  gpreg mtvec_q;
  gpreg mepc_q;
  gpreg mcause_q;
  logic hw_mstatus;

  // Either a trap or a return rewrites mstatus this cycle.
  assign hw_mstatus = trap_take | ret_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: if (!hw_mstatus) begin
            mie_q  <= csr_wdata[MSTATUS_MIE_BIT];
            mpie_q <= csr_wdata[MSTATUS_MPIE_BIT];
          end
          CSR_MTVEC:  mtvec_q <= {csr_wdata[31:2], 2'b00};
          CSR_MEPC:   if (!trap_take) mepc_q <= {csr_wdata[31:2], 2'b00};
          CSR_MCAUSE: if (!trap_take) mcause_q <= csr_wdata;
          default: ;
        endcase
      end
      if (trap_take) begin
        mepc_q   <= {trap_pc[31:2], 2'b00};
        mcause_q <= {28'b0, trap_cause};
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (ret_take) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end
    end
  end

`ifdef TRAP_MTVAL_EN
  gpreg mtval_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mtval_q <= '0;
    end else if (trap_take) begin
      mtval_q <= trap_tval;
    end else if (csr_we && (csr_addr == CSR_MTVAL)) begin
      mtval_q <= csr_wdata;
    end
  end
`else
  // No mtval register in this build: reads as zero, trap value ignored.
  gpreg mtval_q;
  logic unused_tval;
  assign mtval_q     = '0;
  assign unused_tval = ^trap_tval;
`endif

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE_BIT]  = mie_q;
        csr_rdata[MSTATUS_MPIE_BIT] = mpie_q;
      end
      CSR_MTVEC:  csr_rdata = mtvec_q;
      CSR_MEPC:   csr_rdata = mepc_q;
      CSR_MCAUSE: csr_rdata = mcause_q;
      CSR_MTVAL:  csr_rdata = mtval_q;
      default:    csr_rdata = '0;
    endcase
  end

  assign mtvec = mtvec_q;
  assign mepc  = mepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: accepts execution results, takes exceptions and MRETs,
// kills the pipeline, waits for it to drain and then redirects fetch.
// Optional feature: define TRAP_MTVAL_EN to implement the mtval CSR.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   res_valid/res_ready       result handshake (transfer on valid && ready)
//   res, res_pc               execution result and its PC
//   flush                     pipeline kill request (FLUSH and DRAIN)
//   drained                   pipeline-empty acknowledgement
//   redirect_valid/pc         one-cycle fetch redirect strobe and target
//   csr_addr/we/wdata/rdata   CSR access port (combinational read)
//   dbg_state                 current FSM state for observation
// Handshake: a result transfers on a rising edge where res_valid and
// res_ready are both high; res_valid may be held with res_ready low and the
// offer is then simply not taken. res_ready depends only on state.
module trap_ctrl
  import types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  output logic        res_ready,
  input  exec_result  res,
  input  gpreg        res_pc,
  output logic        flush,
  input  logic        drained,
  output logic        redirect_valid,
  output gpreg        redirect_pc,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  gpreg        csr_wdata,
  output gpreg        csr_rdata,
  output state_t      dbg_state
);

  state_t state_q;
  state_t state_d;
  gpreg   target_q;
  gpreg   mtvec;
  gpreg   mepc;
  logic   accept;
  logic   take_ex;
  logic   take_ret;

  assign accept   = (state_q == IDLE) && res_valid;
  // An exception wins over a simultaneous return.
  assign take_ex  = accept && res.ex_valid;
  assign take_ret = accept && res.ret_valid && !res.ex_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Redirect target is frozen at accept; later CSR writes do not move it.
  always_ff @(posedge clk) begin
    if (rst)           target_q <= '0;
    else if (take_ex)  target_q <= mtvec;
    else if (take_ret) target_q <= mepc;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (take_ex || take_ret) state_d = FLUSH;
      FLUSH:    state_d = DRAIN;
      DRAIN:    if (drained) state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    res_ready      = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      IDLE:     res_ready = 1'b1;
      FLUSH:    flush = 1'b1;
      DRAIN:    flush = 1'b1;
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

  trap_csr u_csr (
    .clk        (clk),
    .rst        (rst),
    .trap_take  (take_ex),
    .ret_take   (take_ret),
    .trap_pc    (res_pc),
    .trap_cause (res.ex),
    .trap_tval  (res.ex_tval),
    .csr_addr   (csr_addr),
    .csr_we     (csr_we),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .mtvec      (mtvec),
    .mepc       (mepc)
  );

endmodule
